// File: rtl/sample_streamer.sv
// Plays a 1-bit sample RAM out as LSB-first packed bytes on a valid/ready stream.
// A 2-entry output FIFO and a read-issue throttle keep every sample without stalling at full rate.
module sample_streamer #(
    parameter int ADDR_W = 22,
    parameter int DEPTH  = 4000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] len_r;
    logic              loop_r;
    logic              rd_pend, rd_last;
    logic [7:0]        acc;
    logic [2:0]        acc_cnt;
    logic [1:0]        fifo_cnt;
    logic [7:0]        q0_data, q1_data;
    logic              q0_last, q1_last;

    logic              len_ok, issue, at_end, push, pop;
    logic [3:0]        bits_held;
    logic [7:0]        word;

    always_comb begin
        len_ok    = (length != '0) && ({1'b0, length} <= (ADDR_W+1)'(DEPTH));
        bits_held = {1'b0, acc_cnt} + {3'b000, rd_pend};
        // Hold off a read that would complete a word while the FIFO may still be full.
        issue     = (state == RUN) && (fifo_cnt < 2'd2) &&
                    !(fifo_cnt == 2'd1 && bits_held == 4'd7);
        at_end    = (mem_addr == len_r - ADDR_W'(1));
        word      = acc;
        word[acc_cnt] = mem_data;
        push      = rd_pend && (acc_cnt == 3'd7 || rd_last);
        pop       = m_valid && m_ready;
    end

    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = q0_data;
    assign m_last  = q0_last;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_r    <= '0;
            loop_r   <= 1'b0;
            mem_addr <= '0;
            rd_pend  <= 1'b0;
            rd_last  <= 1'b0;
            acc      <= '0;
            acc_cnt  <= '0;
            fifo_cnt <= '0;
            q0_data  <= '0;
            q1_data  <= '0;
            q0_last  <= 1'b0;
            q1_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                mem_addr <= '0;
                rd_pend  <= 1'b0;
                rd_last  <= 1'b0;
                acc      <= '0;
                acc_cnt  <= '0;
                fifo_cnt <= '0;
                q0_data  <= '0;
                q1_data  <= '0;
                q0_last  <= 1'b0;
                q1_last  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && len_ok) begin
                        state    <= RUN;
                        mem_addr <= '0;
                        len_r    <= length;
                        loop_r   <= loop_en;
                    end
                    RUN: if (issue) begin
                        if (!at_end)     mem_addr <= mem_addr + ADDR_W'(1);
                        else if (loop_r) mem_addr <= '0;
                        else             state    <= DRAIN;
                    end
                    DRAIN: if (pop && q0_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase

                rd_pend <= issue;
                rd_last <= issue && at_end && !loop_r;

                if (rd_pend) begin
                    if (push) begin
                        acc     <= '0;
                        acc_cnt <= '0;
                    end else begin
                        acc     <= word;
                        acc_cnt <= acc_cnt + 3'd1;
                    end
                end

                case ({push, pop})
                    2'b10: begin
                        if (fifo_cnt == 2'd0) begin
                            q0_data <= word;
                            q0_last <= rd_last;
                        end else begin
                            q1_data <= word;
                            q1_last <= rd_last;
                        end
                        fifo_cnt <= fifo_cnt + 2'd1;
                    end
                    2'b01: begin
                        q0_data  <= q1_data;
                        q0_last  <= q1_last;
                        fifo_cnt <= fifo_cnt - 2'd1;
                    end
                    2'b11: begin
                        if (fifo_cnt == 2'd1) begin
                            q0_data <= word;
                            q0_last <= rd_last;
                        end else begin
                            q0_data <= q1_data;
                            q0_last <= q1_last;
                            q1_data <= word;
                            q1_last <= rd_last;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sample_streamer.sv
// Randomized bench for sample_streamer against a word-level model built from the RAM image.
module tb_sample_streamer;
    localparam int ADDR_W = 22;
    localparam int DEPTH  = 4000000;

    logic              clk = 1'b0;
    logic              rst_n, start, stop, loop_en, mem_data, m_ready;
    logic [ADDR_W-1:0] length, mem_addr;
    logic [7:0]        m_data;
    logic              m_valid, m_last, busy, done;

    sample_streamer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .length(length), .mem_addr(mem_addr), .mem_data(mem_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    bit ram [0:255];
    always @(posedge clk) mem_data <= ram[mem_addr[7:0]];

    int tests = 0;
    int fails = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    int done_cnt;
    int max_addr;
    bit collect;

    always @(negedge clk) begin
        if (collect && m_valid && m_ready) got.push_back({m_last, m_data});
        if (done) done_cnt++;
        if (busy && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 256; i++) ram[i] = 1'($urandom_range(1));
    endtask

    // Words the consumer should see: sample s lands in word s/8, bit s%8.
    task automatic build_expected(input int len);
        int nw;
        logic [7:0] v;
        exp_q.delete();
        nw = (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            v = 8'h00;
            for (int b = 0; b < 8; b++)
                if (8 * w + b < len) v[b] = ram[8 * w + b];
            exp_q.push_back({(w == nw - 1), v});
        end
    endtask

    task automatic play(input int len, input int pct, input int budget,
                        output int first_valid, output bit finished);
        got.delete();
        done_cnt    = 0;
        max_addr    = 0;
        collect     = 1'b1;
        first_valid = -1;
        finished    = 1'b0;
        length  = ADDR_W'(len);
        loop_en = 1'b0;
        m_ready = ($urandom_range(99) < pct);
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < budget; c++) begin
            if (first_valid < 0 && m_valid) first_valid = c;
            if (done) begin
                finished = 1'b1;
                break;
            end
            m_ready = ($urandom_range(99) < pct);
            tick();
        end
        m_ready = 1'b0;
        tick();
        tick();
        collect = 1'b0;
    endtask

    task automatic compare_words(input string name, input int len);
        build_expected(len);
        tests++;
        if (got.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s word_count got=%0d want=%0d", name, got.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (got[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL %s word%0d got last=%0b data=%02h want last=%0b data=%02h",
                             name, i, got[i][8], got[i][7:0], exp_q[i][8], exp_q[i][7:0]);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        tests++;
        if ({mem_addr, m_data, m_valid, m_last, busy, done} !== '0) begin
            fails++;
            $display("FAIL %s outputs addr=%0d data=%02h valid=%0b last=%0b busy=%0b done=%0b want all 0",
                     name, mem_addr, m_data, m_valid, m_last, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("after_reset");
    endtask

    task automatic test_single_word();
        int fv;
        bit fin;
        logic [7:0] pat;
        pat = 8'b1000_1101;
        for (int i = 0; i < 8; i++) ram[i] = pat[i];
        play(8, 100, 100, fv, fin);
        tests++;
        if (!fin) begin fails++; $display("FAIL single timeout waiting for done"); end
        tests++;
        if (fv !== 10) begin fails++; $display("FAIL single first_valid got=%0d want=10", fv); end
        tests++;
        if (got.size() != 1 || got[0] !== 9'h18D) begin
            fails++;
            $display("FAIL single word got_n=%0d got=%03h want=18d", got.size(),
                     (got.size() > 0) ? got[0] : 9'h000);
        end
        tests++;
        if (done_cnt != 1) begin fails++; $display("FAIL single done_pulses got=%0d want=1", done_cnt); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL single busy_after got=%0b want=0", busy); end
    endtask

    task automatic test_partial();
        int fv;
        bit fin;
        fill_ram();
        play(11, 100, 100, fv, fin);
        tests++;
        if (!fin) begin fails++; $display("FAIL partial timeout waiting for done"); end
        compare_words("partial", 11);
        tests++;
        if (got.size() == 2 && (got[1][7:3] !== 5'd0 || got[1][8] !== 1'b1)) begin
            fails++;
            $display("FAIL partial pad got=%03h want upper bits 0 and last=1", got[1]);
        end
    endtask

    task automatic test_random_ready();
        int fv;
        bit fin;
        fill_ram();
        play(64, 30, 3000, fv, fin);
        tests++;
        if (!fin) begin fails++; $display("FAIL rand_ready timeout waiting for done"); end
        compare_words("rand_ready", 64);
        tests++;
        if (max_addr > 63) begin fails++; $display("FAIL rand_ready max_addr got=%0d want<=63", max_addr); end
        tests++;
        if (done_cnt != 1) begin fails++; $display("FAIL rand_ready done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int fv;
        bit fin;
        for (int r = 0; r < 5; r++) begin
            int len, pct;
            len = $urandom_range(1, 200);
            pct = $urandom_range(20, 100);
            fill_ram();
            play(len, pct, 5000, fv, fin);
            tests++;
            if (!fin) begin fails++; $display("FAIL b2b%0d timeout len=%0d", r, len); end
            compare_words($sformatf("b2b%0d_len%0d", r, len), len);
        end
    endtask

    task automatic test_loop();
        logic [7:0] w0, w1;
        bit addr_bad;
        fill_ram();
        for (int b = 0; b < 8; b++) begin
            w0[b] = ram[b];
            w1[b] = ram[8 + b];
        end
        got.delete();
        done_cnt = 0;
        collect  = 1'b1;
        addr_bad = 1'b0;
        length   = ADDR_W'(16);
        loop_en  = 1'b1;
        m_ready  = 1'b1;
        start    = 1'b1;
        tick();
        start   = 1'b0;
        loop_en = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (int'(mem_addr) != (c - 1) % 16 && !addr_bad) begin
                addr_bad = 1'b1;
                $display("FAIL loop addr cycle%0d got=%0d want=%0d", c, mem_addr, (c - 1) % 16);
            end
            tick();
        end
        tests++;
        if (addr_bad) fails++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL loop stop valid=%0b busy=%0b want 0 0", m_valid, busy);
        end
        tick();
        tick();
        collect = 1'b0;
        m_ready = 1'b0;
        tests++;
        if (got.size() < 4) begin fails++; $display("FAIL loop word_count got=%0d want>=4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            tests++;
            if (got[i] !== {1'b0, (i % 2 == 0) ? w0 : w1}) begin
                fails++;
                $display("FAIL loop word%0d got=%03h want=%03h", i, got[i], {1'b0, (i % 2 == 0) ? w0 : w1});
            end
        end
        tests++;
        if (done_cnt != 0) begin fails++; $display("FAIL loop done_pulses got=%0d want=0", done_cnt); end
    endtask

    task automatic test_bad_len_and_reset();
        int fv;
        bit fin;
        bit stray;
        done_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            length  = (k == 0) ? '0 : ADDR_W'(DEPTH + 1);
            m_ready = 1'b1;
            start   = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 12; c++) begin
                tests++;
                if (busy !== 1'b0 || m_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL bad_len%0d cycle%0d busy=%0b valid=%0b want 0 0", k, c, busy, m_valid);
                    break;
                end
                tick();
            end
        end
        tests++;
        if (done_cnt != 0) begin fails++; $display("FAIL bad_len done_pulses got=%0d want=0", done_cnt); end

        fill_ram();
        length  = ADDR_W'(64);
        m_ready = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_run_reset");
        tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        stray   = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (m_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        tests++;
        if (stray) begin fails++; $display("FAIL post_reset stray activity seen, want valid=0 busy=0"); end
        play(20, 100, 200, fv, fin);
        tests++;
        if (!fin || fv !== 10) begin
            fails++;
            $display("FAIL restart finished=%0b first_valid=%0d want 1 and 10", fin, fv);
        end
        compare_words("restart", 20);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        length  = '0;
        m_ready = 1'b0;
        collect = 1'b0;
        done_cnt = 0;
        max_addr = 0;
        test_reset();
        test_single_word();
        test_partial();
        test_random_ready();
        test_back_to_back();
        test_loop();
        test_bad_len_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sample_streamer.md
SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, sample RAM address width.
REQ-002 SHALL have parameter DEPTH, default 4000000, number of 1-bit samples in the sample RAM.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin playback; ignored unless in IDLE.
REQ-006 SHALL have port stop  in  1  abort request; honoured in any state.
REQ-007 SHALL have port loop_en  in  1  continuous wrap-around playback when 1; sampled with start.
REQ-008 SHALL have port length  in  ADDR_W  samples to play, 1..DEPTH; sampled with start.
REQ-009 SHALL have port mem_addr  out  ADDR_W  registered read address to the sample RAM.
REQ-010 SHALL have port mem_data  in  1  sample from the RAM, valid exactly one cycle after mem_addr.
REQ-011 SHALL have port m_data  out  8  packed sample word.
REQ-012 SHALL have port m_valid  out  1  m_data/m_last valid.
REQ-013 SHALL have port m_ready  in  1  consumer accepts the word when m_valid and m_ready are both 1.
REQ-014 SHALL have port m_last  out  1  marks the final word of a non-loop playback.
REQ-015 SHALL have port busy  out  1  high in RUN and DRAIN.
REQ-016 SHALL have port done  out  1  one-cycle pulse on normal completion.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start with 1<=length<=DEPTH; RUN->DRAIN after the final address issue of a non-loop playback; DRAIN->IDLE when no read is in flight, the accumulator is empty and the FIFO is empty.
REQ-018 SHALL ignore start when length==0 or length>DEPTH; the block stays in IDLE and done stays 0.
REQ-019 SHALL issue one read per RUN cycle when the issue condition holds; issue condition: FIFO count<2 AND NOT (FIFO count==1 AND accumulated-plus-in-flight bits==7).
REQ-020 SHALL present mem_addr=0 in the first RUN cycle and increment it by 1 after each issue.
REQ-021 SHALL, with loop_en=1, wrap mem_addr from length-1 to 0, never enter DRAIN and never assert m_last.
REQ-022 SHALL capture mem_data one cycle after each issue into an 8-bit accumulator, LSB-first: the k-th sample of a word goes to bit k.
REQ-023 SHALL push a word into a 2-entry FIFO when it holds 8 bits; in DRAIN it SHALL push a partial final word zero-padded in the upper bits.
REQ-024 SHALL drive m_valid=1 whenever the FIFO is non-empty, with m_data/m_last stable until accepted.
REQ-025 SHALL set m_last=1 only on the word containing sample length-1 of a non-loop playback.
REQ-026 SHALL pulse done for one cycle in the cycle after the m_last word is accepted, and return to IDLE in that cycle.
REQ-027 SHALL, with m_ready held 1, sustain one issue per clock cycle with no issue stalls.
REQ-028 SHALL assert the first m_valid 10 cycles after the start cycle when m_ready=1: start in cycle 0, addr 0 in cycle 1, samples in cycles 2..9, word visible in cycle 10.
REQ-029 SHALL never drop or duplicate a sample under any m_ready pattern.
REQ-030 SHALL, on stop, return to IDLE on the next edge and discard any in-flight read, accumulator bits and FIFO contents; m_valid falls that edge and done is not pulsed.
REQ-031 SHALL give stop priority over start when both are asserted in the same cycle.

Reset
REQ-032 SHALL, while rst_n=0, force state IDLE, mem_addr=0, m_data=0, m_valid=0, m_last=0, busy=0 and done=0, and empty the accumulator and FIFO.
REQ-033 SHALL abandon any playback when reset is asserted mid-operation; no output word is presented after rst_n deasserts until a new start.

Verification
REQ-034 SHALL cover: RAM samples 1,0,1,1,0,0,0,1; length=8; m_ready=1 -> one word m_data=0x8D, m_last=1, m_valid first in cycle 10; done pulse follows.
REQ-035 SHALL cover: length=11, m_ready=1 -> two words; the second word holds samples 8..10 in bits 0..2 with bits 3..7 equal to 0 and m_last=1.
REQ-036 SHALL cover: length=64, m_ready toggled randomly (about 30% high) -> eight words bit-exact vs the RAM image; mem_addr never exceeds 63.
REQ-037 SHALL cover: loop_en=1, length=16 -> mem_addr sequence 0..15,0,1,...; words repeat with period 2; m_last and done stay 0; stop -> IDLE next edge with m_valid=0.
REQ-038 SHALL cover: length=0 start -> busy stays 0; then rst_n pulsed low mid-RUN -> all outputs 0, then a new start plays from address 0.
